// File: rtl/i2c_codec_pkg.sv
// Shared codec register type codes, the ordered init write table and sequencer state encoding.
// Imported by both the init sequencer and the I2C initializer so the codes live in one place.
package i2c_codec_pkg;

  localparam int N_WRITES = 11;

  localparam logic [3:0] TYPE_RESET           = 4'h0;
  localparam logic [3:0] TYPE_ANALOG_PATH     = 4'h1;
  localparam logic [3:0] TYPE_DIGITAL_PATH    = 4'h2;
  localparam logic [3:0] TYPE_POWER_DOWN      = 4'h3;
  localparam logic [3:0] TYPE_DIGITAL_FORMAT  = 4'h4;
  localparam logic [3:0] TYPE_SAMPLE          = 4'h5;
  localparam logic [3:0] TYPE_ACTIVE          = 4'h6;
  localparam logic [3:0] TYPE_RIGHT_PHONE_OUT = 4'h7;
  localparam logic [3:0] TYPE_LEFT_PHONE_OUT  = 4'h8;
  localparam logic [3:0] TYPE_RIGHT_LINE_IN   = 4'h9;
  localparam logic [3:0] TYPE_LEFT_LINE_IN    = 4'hA;

  // Write order: reset first, activate last once every other register is set.
  localparam logic [3:0] TYPE_TABLE [N_WRITES] = '{
    TYPE_RESET,
    TYPE_LEFT_LINE_IN,
    TYPE_RIGHT_LINE_IN,
    TYPE_LEFT_PHONE_OUT,
    TYPE_RIGHT_PHONE_OUT,
    TYPE_ANALOG_PATH,
    TYPE_DIGITAL_PATH,
    TYPE_POWER_DOWN,
    TYPE_DIGITAL_FORMAT,
    TYPE_SAMPLE,
    TYPE_ACTIVE
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  function automatic logic [3:0] type_of(input logic [3:0] idx);
    type_of = (idx < 4'(N_WRITES)) ? TYPE_TABLE[idx] : TYPE_RESET;
  endfunction

endpackage

// File: rtl/i2c_codec_init_sequencer.sv
// Walks the 11 codec register writes through the I2C initializer with per-write timeout and retry.
// i_start in IDLE gives o_i2c_start two cycles later; each write waits for i_i2c_finished, then GAP_CYCLES idle.
module i2c_codec_init_sequencer
  import i2c_codec_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY      = 2,
  parameter int CNT_W          = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_i2c_start,
  output logic [3:0] o_i2c_type,
  input  logic       i_i2c_finished,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [3:0] o_step
);

  localparam int                 RETRY_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
  localparam logic [3:0]         LAST_STEP    = 4'(N_WRITES - 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic [3:0]       r_step;
  logic [3:0]       r_type;
  logic             r_advance;
  logic             r_last;
  logic             r_start;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic [3:0]       w_next_step;

  // r_advance distinguishes a successful write from a timeout re-issue of the same step.
  assign w_next_step = r_advance ? (r_step + 4'd1) : r_step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_step    <= 4'd0;
      r_type    <= TYPE_RESET;
      r_advance <= 1'b0;
      r_last    <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            r_state   <= ST_ISSUE;
            r_step    <= 4'd0;
            r_type    <= type_of(4'd0);
            r_retry   <= '0;
            r_advance <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_i2c_finished) begin
            r_state   <= ST_GAP;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_advance <= 1'b1;
            r_last    <= (r_step == LAST_STEP);
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_cnt     <= '0;
            r_advance <= 1'b0;
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + RETRY_W'(1);
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (r_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
              r_step  <= w_next_step;
              r_type  <= type_of(w_next_step);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_i2c_start = r_start;
  assign o_i2c_type  = r_type;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_step      = r_step;

endmodule

// File: tb/tb_i2c_codec_init_sequencer.sv
// Directed bench for the codec init sequencer: an initializer model answers start pulses with a
// configurable delay or not at all, and records every pulse's type and cycle for ordering/spacing checks.
module tb_i2c_codec_init_sequencer;

  localparam int GAP     = 4;
  localparam int TIMEOUT = 256;
  localparam int DELAY   = 30;
  // pulse-to-pulse distance: answer at cnt=d, GAP cycles, one ISSUE cycle, pulse
  localparam int SPACE_OK = DELAY + GAP + 2;
  // timeout at cnt=TIMEOUT-1, then GAP, ISSUE, pulse
  localparam int SPACE_TO = TIMEOUT + GAP + 1;
  localparam logic [3:0] EXP_TYPE [11] = '{4'h0, 4'hA, 4'h9, 4'h8, 4'h7, 4'h1,
                                           4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic       o_i2c_start;
  logic [3:0] o_i2c_type;
  logic       i_i2c_finished;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [3:0] o_step;

  int n_checks = 0;
  int n_fail   = 0;

  // model configuration (written by tests only)
  int ign_lo       = 0;
  int ign_hi       = 0;
  int slow_idx     = -1;
  int gap_spur_idx = -1;
  int spur_req     = 0;

  // model state (written by the model only)
  int         cyc       = 0;
  int         pulse_cnt = 0;
  int         fin_timer = 0;
  int         gap_timer = 0;
  int         spur_ack  = 0;
  logic [3:0] p_type [256];
  int         p_time [256];

  i2c_codec_init_sequencer #(
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(2), .CNT_W(9)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .o_i2c_start(o_i2c_start), .o_i2c_type(o_i2c_type),
    .i_i2c_finished(i_i2c_finished), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_step(o_step)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Initializer model and pulse monitor, evaluated once per negedge.
  initial begin
    bit spur_armed;
    spur_armed = 1'b0;
    i_i2c_finished = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      i_i2c_finished = 1'b0;
      if (gap_timer > 0) begin
        gap_timer--;
        if (gap_timer == 0) i_i2c_finished = 1'b1;
      end
      if (fin_timer > 0) begin
        fin_timer--;
        if (fin_timer == 0) begin
          i_i2c_finished = 1'b1;
          if (spur_armed) begin
            gap_timer  = 2;
            spur_armed = 1'b0;
          end
        end
      end
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        i_i2c_finished = 1'b1;
      end
      if (o_i2c_start === 1'b1) begin
        if (pulse_cnt < 256) begin
          p_type[pulse_cnt] = o_i2c_type;
          p_time[pulse_cnt] = cyc;
        end
        if (!(pulse_cnt >= ign_lo && pulse_cnt < ign_hi))
          fin_timer = (pulse_cnt == slow_idx) ? (TIMEOUT - 1) : DELAY;
        if (pulse_cnt == gap_spur_idx) spur_armed = 1'b1;
        pulse_cnt++;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_end(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_error === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (o_i2c_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", o_i2c_start); end
    n_checks++; if (o_i2c_type !== 4'h0) begin n_fail++; $display("FAIL reset_type: got %h expected 0", o_i2c_type); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_done); end
    n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", o_error); end
    n_checks++; if (o_step !== 4'd0) begin n_fail++; $display("FAIL reset_step: got %0d expected 0", o_step); end
  endtask

  task automatic test_spurious_idle();
    int base;
    base = pulse_cnt;
    @(negedge clk);
    spur_req++;
    repeat (4) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_step !== 4'd0 || o_done !== 1'b0)
      begin n_fail++; $display("FAIL idle_spurious: busy=%b step=%0d done=%b expected 0/0/0", o_busy, o_step, o_done); end
    n_checks++; if (pulse_cnt !== base) begin n_fail++; $display("FAIL idle_spurious_pulses: got %0d expected %0d", pulse_cnt, base); end
  endtask

  task automatic test_nominal();
    int base;
    bit ok;
    base = pulse_cnt;
    gap_spur_idx = base + 4;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++; if (o_i2c_start !== 1'b0 || o_busy !== 1'b1)
      begin n_fail++; $display("FAIL latency_issue: start=%b busy=%b expected 0/1", o_i2c_start, o_busy); end
    @(negedge clk);
    n_checks++; if (o_i2c_start !== 1'b1 || o_i2c_type !== 4'h0)
      begin n_fail++; $display("FAIL latency_pulse: start=%b type=%h expected 1/0", o_i2c_start, o_i2c_type); end
    wait_end(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nominal_end: got no done/error expected done"); end
    repeat (10) @(negedge clk);
    n_checks++; if (pulse_cnt - base !== 11) begin n_fail++; $display("FAIL nominal_count: got %0d expected 11", pulse_cnt - base); end
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (p_type[base + i] !== EXP_TYPE[i]) begin n_fail++; $display("FAIL nominal_type[%0d]: got %h expected %h", i, p_type[base + i], EXP_TYPE[i]); end
    end
    for (int i = 1; i < 11; i++) begin
      n_checks++;
      if (p_time[base + i] - p_time[base + i - 1] !== SPACE_OK)
        begin n_fail++; $display("FAIL nominal_spacing[%0d]: got %0d expected %0d", i, p_time[base + i] - p_time[base + i - 1], SPACE_OK); end
    end
    n_checks++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_error !== 1'b0 || o_step !== 4'd10)
      begin n_fail++; $display("FAIL nominal_final: done=%b busy=%b err=%b step=%0d expected 1/0/0/10", o_done, o_busy, o_error, o_step); end
    gap_spur_idx = -1;
  endtask

  task automatic test_restart_busy_ignore();
    int base;
    bit ok;
    bit seen;
    base = pulse_cnt;
    pulse_start();
    n_checks++; if (o_done !== 1'b0 || o_busy !== 1'b1)
      begin n_fail++; $display("FAIL restart_done_drop: done=%b busy=%b expected 0/1", o_done, o_busy); end
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (o_step === 4'd4) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL busy_reach_step4: got step %0d expected 4", o_step); end
    pulse_start();
    wait_end(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_end: got no done/error expected done"); end
    repeat (5) @(negedge clk);
    n_checks++; if (pulse_cnt - base !== 11) begin n_fail++; $display("FAIL busy_ignore_count: got %0d expected 11", pulse_cnt - base); end
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (p_type[base + i] !== EXP_TYPE[i]) begin n_fail++; $display("FAIL restart_type[%0d]: got %h expected %h", i, p_type[base + i], EXP_TYPE[i]); end
    end
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b expected 1", o_done); end
  endtask

  task automatic test_timeout_recovery();
    int base;
    bit ok;
    logic [3:0] exp_t;
    int exp_s;
    base = pulse_cnt;
    ign_lo = base + 3;
    ign_hi = base + 4;
    pulse_start();
    wait_end(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_end: got no done/error expected done"); end
    repeat (5) @(negedge clk);
    n_checks++; if (pulse_cnt - base !== 12) begin n_fail++; $display("FAIL timeout_count: got %0d expected 12", pulse_cnt - base); end
    for (int i = 0; i < 12; i++) begin
      exp_t = (i < 4) ? EXP_TYPE[(i < 4) ? i : 0] : EXP_TYPE[i - 1];
      n_checks++;
      if (p_type[base + i] !== exp_t) begin n_fail++; $display("FAIL timeout_type[%0d]: got %h expected %h", i, p_type[base + i], exp_t); end
    end
    for (int i = 1; i < 12; i++) begin
      exp_s = (i == 4) ? SPACE_TO : SPACE_OK;
      n_checks++;
      if (p_time[base + i] - p_time[base + i - 1] !== exp_s)
        begin n_fail++; $display("FAIL timeout_spacing[%0d]: got %0d expected %0d", i, p_time[base + i] - p_time[base + i - 1], exp_s); end
    end
    n_checks++; if (o_done !== 1'b1 || o_error !== 1'b0)
      begin n_fail++; $display("FAIL timeout_final: done=%b err=%b expected 1/0", o_done, o_error); end
  endtask

  task automatic test_coincident();
    int base;
    bit ok;
    base = pulse_cnt;
    slow_idx = base + 2;
    pulse_start();
    wait_end(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL coincident_end: got no done/error expected done"); end
    repeat (5) @(negedge clk);
    n_checks++; if (pulse_cnt - base !== 11) begin n_fail++; $display("FAIL coincident_count: got %0d expected 11", pulse_cnt - base); end
    n_checks++; if (p_type[base + 3] !== 4'h8) begin n_fail++; $display("FAIL coincident_next_type: got %h expected 8", p_type[base + 3]); end
    n_checks++; if (p_time[base + 3] - p_time[base + 2] !== SPACE_TO)
      begin n_fail++; $display("FAIL coincident_spacing: got %0d expected %0d", p_time[base + 3] - p_time[base + 2], SPACE_TO); end
    n_checks++; if (o_done !== 1'b1 || o_error !== 1'b0)
      begin n_fail++; $display("FAIL coincident_final: done=%b err=%b expected 1/0", o_done, o_error); end
    slow_idx = -1;
  endtask

  task automatic test_retry_exhaustion();
    int base;
    int held;
    bit ok;
    base = pulse_cnt;
    ign_lo = base + 5;
    ign_hi = base + 8;
    pulse_start();
    wait_end(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL exhaust_end: got no done/error expected error"); end
    n_checks++; if (o_error !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_step !== 4'd5)
      begin n_fail++; $display("FAIL exhaust_final: err=%b busy=%b done=%b step=%0d expected 1/0/0/5", o_error, o_busy, o_done, o_step); end
    n_checks++; if (pulse_cnt - base !== 8) begin n_fail++; $display("FAIL exhaust_count: got %0d expected 8", pulse_cnt - base); end
    for (int i = 5; i < 8; i++) begin
      n_checks++;
      if (p_type[base + i] !== 4'h1) begin n_fail++; $display("FAIL exhaust_type[%0d]: got %h expected 1", i, p_type[base + i]); end
    end
    held = pulse_cnt;
    repeat (300) @(negedge clk);
    n_checks++; if (pulse_cnt !== held || o_error !== 1'b1)
      begin n_fail++; $display("FAIL exhaust_hold: pulses=%0d err=%b expected %0d/1", pulse_cnt, o_error, held); end
    base = pulse_cnt;
    pulse_start();
    n_checks++; if (o_error !== 1'b0 || o_busy !== 1'b1)
      begin n_fail++; $display("FAIL error_restart: err=%b busy=%b expected 0/1", o_error, o_busy); end
    wait_end(1000, ok);
    repeat (2) @(negedge clk);
    n_checks++; if (!ok || o_done !== 1'b1 || pulse_cnt - base !== 11 || p_type[base] !== 4'h0)
      begin n_fail++; $display("FAIL error_restart_seq: done=%b pulses=%0d first=%h expected 1/11/0", o_done, pulse_cnt - base, p_type[base]); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen;
    base = pulse_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (pulse_cnt >= base + 8) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach: got %0d pulses expected 8", pulse_cnt - base); end
    repeat (5) @(negedge clk);
    n_checks++; if (o_busy !== 1'b1 || o_step !== 4'd7 || o_i2c_type !== 4'h3)
      begin n_fail++; $display("FAIL rstmid_pre: busy=%b step=%0d type=%h expected 1/7/3", o_busy, o_step, o_i2c_type); end
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_busy !== 1'b0 || o_step !== 4'd0 || o_i2c_type !== 4'h0 || o_done !== 1'b0 || o_error !== 1'b0 || o_i2c_start !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_async: busy=%b step=%0d type=%h done=%b err=%b start=%b expected all 0",
                               o_busy, o_step, o_i2c_type, o_done, o_error, o_i2c_start); end
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    base = pulse_cnt;
    repeat (60) @(negedge clk);
    n_checks++; if (pulse_cnt !== base || o_busy !== 1'b0 || o_step !== 4'd0 || o_done !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_idle: pulses=%0d busy=%b step=%0d done=%b expected 0/0/0/0", pulse_cnt - base, o_busy, o_step, o_done); end
  endtask

  initial begin
    i_start = 1'b0;
    i_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    test_reset();
    test_spurious_idle();
    test_nominal();
    test_restart_busy_ignore();
    test_timeout_recovery();
    test_coincident();
    test_retry_exhaustion();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
